rll27_enc_stream: RTL and testbench

- Streaming RLL(2,7) encoder. It is the parametrised successor to the fixed serial-in encoder with 4/6/8-bit result ports.
- Consumes one data bit per beat over a valid/ready handshake and parses variable-length groups (2/3/4 bits) with a prefix state machine.
- Completed codewords are queued in a FIFO of configurable depth and presented on a valid/ready output, together with length and pad information.
- Supports explicit flush of a partial group. Sits between the bit source and the line serialiser / write channel.

---
 rtl/rll27_enc_stream_if.sv | 23 ++
 rtl/rll27_enc_stream.sv | 184 ++++++++++++++++++
 tb/tb_rll27_enc_stream.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/rll27_enc_stream_if.sv
// Handshake bundle for the RLL(2,7) stream encoder: a bit-input channel and a codeword output channel.
// The encoder uses the slave modport; the bit source and the word consumer use the master modport.
interface rll27_enc_stream_if;
   logic       data_bit_i;
   logic       data_valid_i;
   logic       flush_i;
   logic       data_ready_o;
   logic [7:0] cw_o;
   logic [1:0] cw_len_o;
   logic [1:0] cw_pad_o;
   logic       cw_valid_o;
   logic       cw_ready_i;

   modport slave (
      input  data_bit_i, data_valid_i, flush_i, cw_ready_i,
      output data_ready_o, cw_o, cw_len_o, cw_pad_o, cw_valid_o
   );

   modport master (
      output data_bit_i, data_valid_i, flush_i, cw_ready_i,
      input  data_ready_o, cw_o, cw_len_o, cw_pad_o, cw_valid_o
   );
endinterface

// File: rtl/rll27_enc_stream.sv
// Streaming RLL(2,7) encoder: prefix parser feeding a codeword FIFO with flush padding.
// Optional per-length emitted-word counters are built only when RLL_STATS_EN is defined.
module rll27_enc_stream #(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   rll27_enc_stream_if.slave bus,
   input  logic             stat_clr_i,
   output logic [CNT_W-1:0] stat4_o,
   output logic [CNT_W-1:0] stat6_o,
   output logic [CNT_W-1:0] stat8_o
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   typedef enum logic [2:0] {IDLE, S1, S0, S00, S01, S001} state_t;

   typedef struct packed {
      logic [7:0] cw;
      logic [1:0] len;
      logic [1:0] pad;
   } entry_t;

   state_t           state_q, state_d, mid_state;
   logic             run_q;
   logic [PTR_W:0]   count_q, count_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   entry_t           mem_q [FIFO_DEPTH];
   entry_t           mem_d [FIFO_DEPTH];
   entry_t           push_entry, head;
   logic             fifo_full, ready, beat_acc, flush_acc;
   logic             beat_emit, push, pop, cw_valid;

   assign fifo_full = (count_q == CNT_FULL);
   assign ready     = run_q & ~fifo_full;
   assign beat_acc  = bus.data_valid_i & ready;
   assign flush_acc = bus.flush_i & ready;
   assign cw_valid  = (count_q != '0);
   assign pop       = cw_valid & bus.cw_ready_i;
   assign head      = mem_q[rd_ptr_q];

   // The accepted bit is parsed first; a flush then pads whatever group is still open.
   always_comb begin
      mid_state  = state_q;
      beat_emit  = 1'b0;
      push_entry = '0;
      if (beat_acc) begin
         unique case (state_q)
            IDLE: mid_state = bus.data_bit_i ? S1 : S0;
            S1: begin
               mid_state  = IDLE;
               beat_emit  = 1'b1;
               push_entry = '{cw: bus.data_bit_i ? 8'h80 : 8'h40, len: 2'd1, pad: 2'd0};
            end
            S0: mid_state = bus.data_bit_i ? S01 : S00;
            S00: begin
               if (bus.data_bit_i) begin
                  mid_state = S001;
               end else begin
                  mid_state  = IDLE;
                  beat_emit  = 1'b1;
                  push_entry = '{cw: 8'h10, len: 2'd2, pad: 2'd0};
               end
            end
            S01: begin
               mid_state  = IDLE;
               beat_emit  = 1'b1;
               push_entry = '{cw: bus.data_bit_i ? 8'h20 : 8'h90, len: 2'd2, pad: 2'd0};
            end
            S001: begin
               mid_state  = IDLE;
               beat_emit  = 1'b1;
               push_entry = '{cw: bus.data_bit_i ? 8'h08 : 8'h24, len: 2'd3, pad: 2'd0};
            end
            default: mid_state = IDLE;
         endcase
      end
      state_d = mid_state;
      push    = beat_emit;
      if (flush_acc && !beat_emit) begin
         state_d = IDLE;
         unique case (mid_state)
            S1:   begin push = 1'b1; push_entry = '{cw: 8'h40, len: 2'd1, pad: 2'd1}; end
            S0:   begin push = 1'b1; push_entry = '{cw: 8'h10, len: 2'd2, pad: 2'd2}; end
            S00:  begin push = 1'b1; push_entry = '{cw: 8'h10, len: 2'd2, pad: 2'd1}; end
            S01:  begin push = 1'b1; push_entry = '{cw: 8'h90, len: 2'd2, pad: 2'd1}; end
            S001: begin push = 1'b1; push_entry = '{cw: 8'h24, len: 2'd3, pad: 2'd1}; end
            default: push = 1'b0;
         endcase
      end
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_entry;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push && !pop) begin
         count_d = count_q + CNT_ONE;
      end else if (pop && !push) begin
         count_d = count_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= IDLE;
         run_q    <= 1'b0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         run_q    <= 1'b1;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: the emptied count hides stale entries.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   assign bus.data_ready_o = ready;
   assign bus.cw_valid_o   = cw_valid;
   assign bus.cw_o         = cw_valid ? head.cw  : 8'h00;
   assign bus.cw_len_o     = cw_valid ? head.len : 2'd0;
   assign bus.cw_pad_o     = cw_valid ? head.pad : 2'd0;

`ifdef RLL_STATS_EN
   logic [CNT_W-1:0] stat4_q, stat4_d, stat6_q, stat6_d, stat8_q, stat8_d;
   localparam logic [CNT_W-1:0] STAT_ONE = CNT_W'(1);

   always_comb begin
      stat4_d = stat4_q;
      stat6_d = stat6_q;
      stat8_d = stat8_q;
      if (stat_clr_i) begin
         stat4_d = '0;
         stat6_d = '0;
         stat8_d = '0;
      end else if (pop) begin
         if (head.len == 2'd1 && stat4_q != '1) stat4_d = stat4_q + STAT_ONE;
         if (head.len == 2'd2 && stat6_q != '1) stat6_d = stat6_q + STAT_ONE;
         if (head.len == 2'd3 && stat8_q != '1) stat8_d = stat8_q + STAT_ONE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stat4_q <= '0;
         stat6_q <= '0;
         stat8_q <= '0;
      end else begin
         stat4_q <= stat4_d;
         stat6_q <= stat6_d;
         stat8_q <= stat8_d;
      end
   end

   assign stat4_o = stat4_q;
   assign stat6_o = stat6_q;
   assign stat8_o = stat8_q;
`else
   logic unused_stat_clr;
   assign unused_stat_clr = stat_clr_i;
   assign stat4_o = '0;
   assign stat6_o = '0;
   assign stat8_o = '0;
`endif
endmodule

// File: tb/tb_rll27_enc_stream.sv
// Scoreboard bench for rll27_enc_stream: stimulus queues hand-derived codewords, a monitor pops and compares.
// Statistics expectations follow the RLL_STATS_EN build setting.
module tb_rll27_enc_stream;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        stat_clr_i = 1'b0;
   logic [15:0] stat4_o, stat6_o, stat8_o;

   rll27_enc_stream_if bus ();

   rll27_enc_stream #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .bus        (bus.slave),
      .stat_clr_i (stat_clr_i),
      .stat4_o    (stat4_o),
      .stat6_o    (stat6_o),
      .stat8_o    (stat8_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [7:0] cw;
      logic [1:0] len;
      logic [1:0] pad;
   } exp_t;

   exp_t sb[$];
   int   checks_total  = 0;
   int   checks_passed = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks_total++;
      if (act === exp) checks_passed++;
      else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic expectWord(input logic [7:0] cw, input logic [1:0] len, input logic [1:0] pad);
      exp_t e;
      e.cw  = cw;
      e.len = len;
      e.pad = pad;
      sb.push_back(e);
   endtask

   // Called just after a rising edge; holds the beat until it is accepted.
   task automatic applyStimulus(input logic valid, input logic b, input logic fl);
      int budget;
      budget = 0;
      bus.data_valid_i = valid;
      bus.data_bit_i   = b;
      bus.flush_i      = fl;
      @(negedge clk_i);
      while (!bus.data_ready_o && budget < 200) begin
         budget++;
         @(negedge clk_i);
      end
      if (!bus.data_ready_o) checkOutput("beat_ready_timeout", {31'b0, bus.data_ready_o}, 32'd1);
      @(posedge clk_i);
      #1;
      bus.data_valid_i = 1'b0;
      bus.data_bit_i   = 1'b0;
      bus.flush_i      = 1'b0;
   endtask

   task automatic sendBits(input logic [31:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) applyStimulus(1'b1, bits[i], 1'b0);
   endtask

   task automatic waitDrain();
      int budget;
      budget = 0;
      @(negedge clk_i);
      while ((sb.size() != 0 || bus.cw_valid_o) && budget < 200) begin
         budget++;
         @(negedge clk_i);
      end
      if (sb.size() != 0 || bus.cw_valid_o) checkOutput("drain_timeout", sb.size(), 32'd0);
      @(posedge clk_i);
      #1;
   endtask

   always @(negedge clk_i) begin
      if (rst_i && bus.cw_valid_o && bus.cw_ready_i) begin
         if (sb.size() == 0) begin
            checks_total++;
            $display("[TB] FAIL unexpected_word: got cw=%0h len=%0d, expected none", bus.cw_o, bus.cw_len_o);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("cw", {24'b0, bus.cw_o}, {24'b0, e.cw});
            checkOutput("cw_len", {30'b0, bus.cw_len_o}, {30'b0, e.len});
            checkOutput("cw_pad", {30'b0, bus.cw_pad_o}, {30'b0, e.pad});
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.data_bit_i   = 1'b0;
      bus.data_valid_i = 1'b0;
      bus.flush_i      = 1'b0;
      bus.cw_ready_i   = 1'b1;
      repeat (2) @(negedge clk_i);
      checkOutput("rst_ready", {31'b0, bus.data_ready_o}, 32'd0);
      checkOutput("rst_valid", {31'b0, bus.cw_valid_o}, 32'd0);
      checkOutput("rst_cw", {24'b0, bus.cw_o}, 32'd0);
      checkOutput("rst_len", {30'b0, bus.cw_len_o}, 32'd0);
      checkOutput("rst_pad", {30'b0, bus.cw_pad_o}, 32'd0);
      checkOutput("rst_stat4", {16'b0, stat4_o}, 32'd0);

      @(posedge clk_i); #1; rst_i = 1'b1;
      @(negedge clk_i);
      checkOutput("ready_before_edge", {31'b0, bus.data_ready_o}, 32'd0);
      @(negedge clk_i);
      checkOutput("ready_after_edge", {31'b0, bus.data_ready_o}, 32'd1);
      @(posedge clk_i); #1;

      // 32-bit stream followed by a flush of the trailing "00".
      expectWord(8'h80, 2'd1, 2'd0); expectWord(8'h10, 2'd2, 2'd0); expectWord(8'h40, 2'd1, 2'd0);
      expectWord(8'h20, 2'd2, 2'd0); expectWord(8'h80, 2'd1, 2'd0); expectWord(8'h10, 2'd2, 2'd0);
      expectWord(8'h40, 2'd1, 2'd0); expectWord(8'h40, 2'd1, 2'd0); expectWord(8'h80, 2'd1, 2'd0);
      expectWord(8'h40, 2'd1, 2'd0); expectWord(8'h40, 2'd1, 2'd0); expectWord(8'h40, 2'd1, 2'd0);
      expectWord(8'h20, 2'd2, 2'd0); expectWord(8'h10, 2'd2, 2'd1);
      sendBits(32'hC4F1_5D4C, 32);
      applyStimulus(1'b0, 1'b0, 1'b1);
      waitDrain();
`ifdef RLL_STATS_EN
      checkOutput("stat4", {16'b0, stat4_o}, 32'd9);
      checkOutput("stat6", {16'b0, stat6_o}, 32'd5);
      checkOutput("stat8", {16'b0, stat8_o}, 32'd0);
`else
      checkOutput("stat4", {16'b0, stat4_o}, 32'd0);
      checkOutput("stat6", {16'b0, stat6_o}, 32'd0);
      checkOutput("stat8", {16'b0, stat8_o}, 32'd0);
`endif

      // 8-bit and 6-bit words from 0010, 0011, 010.
      expectWord(8'h24, 2'd3, 2'd0); expectWord(8'h08, 2'd3, 2'd0); expectWord(8'h90, 2'd2, 2'd0);
      sendBits(32'b0010, 4);
      sendBits(32'b0011, 4);
      sendBits(32'b010, 3);
      waitDrain();

      // Fill the FIFO with the consumer stalled, then release it.
      bus.cw_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) expectWord(8'h80, 2'd1, 2'd0);
      sendBits(32'hFF, 8);
      @(negedge clk_i);
      checkOutput("full_ready", {31'b0, bus.data_ready_o}, 32'd0);
      checkOutput("full_valid", {31'b0, bus.cw_valid_o}, 32'd1);
      checkOutput("full_head", {24'b0, bus.cw_o}, 32'h80);
      @(posedge clk_i); #1; bus.cw_ready_i = 1'b1;
      @(negedge clk_i);
      checkOutput("ready_during_first_pop", {31'b0, bus.data_ready_o}, 32'd0);
      @(negedge clk_i);
      checkOutput("ready_after_first_pop", {31'b0, bus.data_ready_o}, 32'd1);
      @(posedge clk_i); #1;
      sendBits(32'b11, 2);
      waitDrain();

      // Flush of a lone "0" pads two bits; flush in IDLE emits nothing.
      expectWord(8'h10, 2'd2, 2'd2);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      waitDrain();
      applyStimulus(1'b0, 1'b0, 1'b1);
      repeat (4) @(negedge clk_i);
      checkOutput("idle_flush_no_word", {31'b0, bus.cw_valid_o}, 32'd0);
      @(posedge clk_i); #1;

      // A beat that completes a word makes a simultaneous flush a no-op.
      expectWord(8'h80, 2'd1, 2'd0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1);
      waitDrain();

      // Mid-stream reset discards queued words and the open group.
      bus.cw_ready_i = 1'b0;
      sendBits(32'b1011, 4);
      sendBits(32'b00, 2);
      @(negedge clk_i);
      checkOutput("queued_before_reset", {31'b0, bus.cw_valid_o}, 32'd1);
      rst_i = 1'b0;
      #1;
      checkOutput("midrst_valid", {31'b0, bus.cw_valid_o}, 32'd0);
      checkOutput("midrst_cw", {24'b0, bus.cw_o}, 32'd0);
      checkOutput("midrst_len", {30'b0, bus.cw_len_o}, 32'd0);
      checkOutput("midrst_pad", {30'b0, bus.cw_pad_o}, 32'd0);
      checkOutput("midrst_ready", {31'b0, bus.data_ready_o}, 32'd0);
      checkOutput("midrst_stat4", {16'b0, stat4_o}, 32'd0);
      sb.delete();
      @(posedge clk_i); #1; rst_i = 1'b1; bus.cw_ready_i = 1'b1;
      @(posedge clk_i); #1;
      expectWord(8'h40, 2'd1, 2'd0);
      sendBits(32'b10, 2);
      waitDrain();
`ifdef RLL_STATS_EN
      checkOutput("stat4_after_reset", {16'b0, stat4_o}, 32'd1);
`else
      checkOutput("stat4_after_reset", {16'b0, stat4_o}, 32'd0);
`endif

      stat_clr_i = 1'b1;
      @(posedge clk_i); #1;
      stat_clr_i = 1'b0;
      checkOutput("stat4_cleared", {16'b0, stat4_o}, 32'd0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end
endmodule
